cache_axi_arbiter: RTL and testbench

Shares the single AXI master port of the core between the instruction cache (read-only) and the data cache (read and write). The block arbitrates refill reads round-robin, registers each granted address request, and steers burst data back to the owner. It forwards dcache write-backs and uncached stores through a separate write FSM. It also holds off a dcache read that targets the 16-byte line currently being written back. It sits between the two cache FSMs and the top-level AXI interface.

---
 rtl/axi_arb_pkg.sv | 22 ++
 rtl/cache_axi_arbiter_rr_arb2.sv | 29 ++
 rtl/cache_axi_arbiter.sv | 183 ++++++++++++++++++
 tb/tb_cache_axi_arbiter.sv | 349 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi_arb_pkg.sv
// Shared types for the cache-to-AXI arbiter.
// FSM encodings, AXI IDs and the line offset used by the hazard check.
package axi_arb_pkg;

  typedef enum logic [1:0] {
    R_IDLE,
    R_ADDR,
    R_DATA
  } rd_state_t;

  typedef enum logic [1:0] {
    W_IDLE,
    W_ADDR,
    W_DATA,
    W_RESP
  } wr_state_t;

  localparam int unsigned ID_ICACHE = 0;
  localparam int unsigned ID_DCACHE = 1;
  localparam int unsigned LINE_OFS  = 4;

endpackage

// File: rtl/cache_axi_arbiter_rr_arb2.sv
// Two-requester round-robin grant.
// Bit 0 is the icache, bit 1 the dcache; last holds the last served index.
module rr_arb2 (
  input  logic       clk,
  input  logic       rstn,
  input  logic [1:0] req,
  input  logic       upd,
  input  logic       upd_idx,
  output logic [1:0] gnt
);

  logic last;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      last <= 1'b1;
    end else if (upd) begin
      last <= upd_idx;
    end
  end

  always_comb begin
    gnt = req;
    if (req == 2'b11) begin
      gnt = last ? 2'b01 : 2'b10;
    end
  end

endmodule

// File: rtl/cache_axi_arbiter.sv
// Shares one AXI master port between icache reads and dcache reads/writes.
// Independent read and write FSMs; dcache reads wait on a line being written.
module cache_axi_arbiter
  import axi_arb_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int ID_W   = 4
) (
  input  logic                clk,
  input  logic                rstn,
  input  logic                i_arvalid,
  output logic                i_arready,
  input  logic [ADDR_W-1:0]   i_araddr,
  input  logic [7:0]          i_arlen,
  input  logic [2:0]          i_arsize,
  output logic                i_rvalid,
  output logic                i_rlast,
  input  logic                i_rready,
  output logic [DATA_W-1:0]   i_rdata,
  input  logic                d_arvalid,
  output logic                d_arready,
  input  logic [ADDR_W-1:0]   d_araddr,
  input  logic [7:0]          d_arlen,
  input  logic [2:0]          d_arsize,
  output logic                d_rvalid,
  output logic                d_rlast,
  input  logic                d_rready,
  output logic [DATA_W-1:0]   d_rdata,
  input  logic                d_awvalid,
  output logic                d_awready,
  input  logic [ADDR_W-1:0]   d_awaddr,
  input  logic [7:0]          d_awlen,
  input  logic [2:0]          d_awsize,
  input  logic                d_wvalid,
  input  logic [DATA_W-1:0]   d_wdata,
  input  logic [DATA_W/8-1:0] d_wstrb,
  input  logic                d_wlast,
  output logic                d_wready,
  output logic                d_bvalid,
  input  logic                d_bready,
  output logic                arvalid,
  output logic [ADDR_W-1:0]   araddr,
  output logic [7:0]          arlen,
  output logic [2:0]          arsize,
  output logic [ID_W-1:0]     arid,
  input  logic                arready,
  input  logic                rvalid,
  input  logic [DATA_W-1:0]   rdata,
  input  logic                rlast,
  input  logic [ID_W-1:0]     rid,
  output logic                rready,
  output logic                awvalid,
  output logic [ADDR_W-1:0]   awaddr,
  output logic [7:0]          awlen,
  output logic [2:0]          awsize,
  output logic [ID_W-1:0]     awid,
  input  logic                awready,
  output logic                wvalid,
  output logic [DATA_W-1:0]   wdata,
  output logic [DATA_W/8-1:0] wstrb,
  output logic                wlast,
  input  logic                wready,
  input  logic                bvalid,
  input  logic [1:0]          bresp,
  output logic                bready
);

  rd_state_t  rs, rs_n;
  wr_state_t  ws, ws_n;
  logic       own;
  logic       d_ok;
  logic       r_idle, r_data, rd_done;
  logic       w_data, w_resp;
  logic [1:0] gnt;
  logic       unused;

  assign unused = ^{rid, bresp};

  // A dcache read must not overtake a write-back of the same line.
  assign d_ok = d_arvalid
    & ~((ws != W_IDLE)
    & (d_araddr[ADDR_W-1:LINE_OFS]
       == awaddr[ADDR_W-1:LINE_OFS]));

  assign r_idle  = (rs == R_IDLE);
  assign r_data  = (rs == R_DATA);
  assign rd_done = r_data & rvalid & rready & rlast;

  rr_arb2 u_arb (
    .clk     (clk),
    .rstn    (rstn),
    .req     ({d_ok, i_arvalid}),
    .upd     (rd_done),
    .upd_idx (own),
    .gnt     (gnt)
  );

  assign i_arready = r_idle & gnt[0];
  assign d_arready = r_idle & gnt[1];
  assign arvalid   = (rs == R_ADDR);

  always_comb begin
    rs_n = rs;
    unique case (rs)
      R_IDLE: if (|gnt) rs_n = R_ADDR;
      R_ADDR: if (arready) rs_n = R_DATA;
      R_DATA: if (rd_done) rs_n = R_IDLE;
      default: rs_n = R_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rs     <= R_IDLE;
      own    <= 1'b0;
      araddr <= '0;
      arlen  <= '0;
      arsize <= '0;
      arid   <= '0;
    end else begin
      rs <= rs_n;
      if (r_idle & |gnt) begin
        own    <= gnt[1];
        araddr <= gnt[1] ? d_araddr : i_araddr;
        arlen  <= gnt[1] ? d_arlen : i_arlen;
        arsize <= gnt[1] ? d_arsize : i_arsize;
        arid   <= gnt[1] ? ID_W'(ID_DCACHE)
                         : ID_W'(ID_ICACHE);
      end
    end
  end

  assign i_rvalid = r_data & ~own & rvalid;
  assign d_rvalid = r_data & own & rvalid;
  assign i_rlast  = r_data & ~own & rlast;
  assign d_rlast  = r_data & own & rlast;
  assign i_rdata  = (r_data & ~own) ? rdata : '0;
  assign d_rdata  = (r_data & own) ? rdata : '0;
  assign rready   = r_data & (own ? d_rready : i_rready);

  assign w_data    = (ws == W_DATA);
  assign w_resp    = (ws == W_RESP);
  assign d_awready = (ws == W_IDLE) & d_awvalid;
  assign awvalid   = (ws == W_ADDR);
  assign wvalid    = w_data & d_wvalid;
  assign d_wready  = w_data & wready;
  assign wdata     = w_data ? d_wdata : '0;
  assign wstrb     = w_data ? d_wstrb : '0;
  assign wlast     = w_data & d_wlast;
  assign d_bvalid  = w_resp & bvalid;
  assign bready    = w_resp & d_bready;

  always_comb begin
    ws_n = ws;
    unique case (ws)
      W_IDLE: if (d_awvalid) ws_n = W_ADDR;
      W_ADDR: if (awready) ws_n = W_DATA;
      W_DATA: if (d_wvalid & wready & d_wlast) ws_n = W_RESP;
      W_RESP: if (bvalid & d_bready) ws_n = W_IDLE;
      default: ws_n = W_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      ws     <= W_IDLE;
      awaddr <= '0;
      awlen  <= '0;
      awsize <= '0;
      awid   <= '0;
    end else begin
      ws <= ws_n;
      if (d_awready) begin
        awaddr <= d_awaddr;
        awlen  <= d_awlen;
        awsize <= d_awsize;
        awid   <= ID_W'(ID_DCACHE);
      end
    end
  end

endmodule

// File: tb/tb_cache_axi_arbiter.sv
// Directed bench for cache_axi_arbiter.
// Inputs change 1ns after the rising edge; outputs are checked 1ns later.
module tb_cache_axi_arbiter;

  logic        clk = 1'b0;
  logic        rstn;
  logic        i_arvalid, i_arready, i_rvalid, i_rlast, i_rready;
  logic [31:0] i_araddr, i_rdata;
  logic [7:0]  i_arlen;
  logic [2:0]  i_arsize;
  logic        d_arvalid, d_arready, d_rvalid, d_rlast, d_rready;
  logic [31:0] d_araddr, d_rdata;
  logic [7:0]  d_arlen;
  logic [2:0]  d_arsize;
  logic        d_awvalid, d_awready;
  logic [31:0] d_awaddr;
  logic [7:0]  d_awlen;
  logic [2:0]  d_awsize;
  logic        d_wvalid, d_wlast, d_wready;
  logic [31:0] d_wdata;
  logic [3:0]  d_wstrb;
  logic        d_bvalid, d_bready;
  logic        arvalid, arready;
  logic [31:0] araddr;
  logic [7:0]  arlen;
  logic [2:0]  arsize;
  logic [3:0]  arid;
  logic        rvalid, rlast, rready;
  logic [31:0] rdata;
  logic [3:0]  rid;
  logic        awvalid, awready;
  logic [31:0] awaddr;
  logic [7:0]  awlen;
  logic [2:0]  awsize;
  logic [3:0]  awid;
  logic        wvalid, wlast, wready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        bvalid, bready;
  logic [1:0]  bresp;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  cache_axi_arbiter dut (
    .clk(clk), .rstn(rstn),
    .i_arvalid(i_arvalid), .i_arready(i_arready),
    .i_araddr(i_araddr), .i_arlen(i_arlen),
    .i_arsize(i_arsize), .i_rvalid(i_rvalid),
    .i_rlast(i_rlast), .i_rready(i_rready),
    .i_rdata(i_rdata),
    .d_arvalid(d_arvalid), .d_arready(d_arready),
    .d_araddr(d_araddr), .d_arlen(d_arlen),
    .d_arsize(d_arsize), .d_rvalid(d_rvalid),
    .d_rlast(d_rlast), .d_rready(d_rready),
    .d_rdata(d_rdata),
    .d_awvalid(d_awvalid), .d_awready(d_awready),
    .d_awaddr(d_awaddr), .d_awlen(d_awlen),
    .d_awsize(d_awsize), .d_wvalid(d_wvalid),
    .d_wdata(d_wdata), .d_wstrb(d_wstrb),
    .d_wlast(d_wlast), .d_wready(d_wready),
    .d_bvalid(d_bvalid), .d_bready(d_bready),
    .arvalid(arvalid), .araddr(araddr),
    .arlen(arlen), .arsize(arsize), .arid(arid),
    .arready(arready), .rvalid(rvalid),
    .rdata(rdata), .rlast(rlast), .rid(rid),
    .rready(rready), .awvalid(awvalid),
    .awaddr(awaddr), .awlen(awlen),
    .awsize(awsize), .awid(awid),
    .awready(awready), .wvalid(wvalid),
    .wdata(wdata), .wstrb(wstrb), .wlast(wlast),
    .wready(wready), .bvalid(bvalid),
    .bresp(bresp), .bready(bready)
  );

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h t=%0t",
               tag, got, exp, $time);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic settle;
    #1;
  endtask

  // Called in R_ADDR: check the bus request, then accept it.
  task automatic do_ar(input logic [31:0] addr,
                       input logic [3:0]  id);
    settle;
    chk("arvalid", {63'd0, arvalid}, 64'd1);
    chk("araddr", {32'd0, araddr}, {32'd0, addr});
    chk("arid", {60'd0, arid}, {60'd0, id});
    arready = 1'b1;
    tick;
    arready = 1'b0;
  endtask

  // Called in R_DATA: feed a burst and check steering.
  task automatic do_r(input bit dc, input int beats);
    logic [31:0] v;
    for (int k = 0; k < beats; k++) begin
      v = 32'hA000_0000 + 32'(k);
      rvalid   = 1'b1;
      rdata    = v;
      rlast    = (k == beats - 1);
      i_rready = 1'b1;
      d_rready = 1'b1;
      settle;
      chk("own_rvalid", {63'd0, dc ? d_rvalid : i_rvalid}, 64'd1);
      chk("oth_rvalid", {63'd0, dc ? i_rvalid : d_rvalid}, 64'd0);
      chk("own_rdata", {32'd0, dc ? d_rdata : i_rdata}, {32'd0, v});
      chk("own_rlast", {63'd0, dc ? d_rlast : i_rlast},
          {63'd0, (k == beats - 1)});
      chk("rready", {63'd0, rready}, 64'd1);
      tick;
    end
    rvalid   = 1'b0;
    rlast    = 1'b0;
    i_rready = 1'b0;
    d_rready = 1'b0;
  endtask

  task automatic chk_reset;
    chk("rst_arvalid", {63'd0, arvalid}, 64'd0);
    chk("rst_araddr", {32'd0, araddr}, 64'd0);
    chk("rst_arid", {60'd0, arid}, 64'd0);
    chk("rst_awvalid", {63'd0, awvalid}, 64'd0);
    chk("rst_awaddr", {32'd0, awaddr}, 64'd0);
    chk("rst_wvalid", {63'd0, wvalid}, 64'd0);
    chk("rst_wstrb", {60'd0, wstrb}, 64'd0);
    chk("rst_rready", {63'd0, rready}, 64'd0);
    chk("rst_i_rvalid", {63'd0, i_rvalid}, 64'd0);
    chk("rst_d_bvalid", {63'd0, d_bvalid}, 64'd0);
  endtask

  bit exp_dc[3] = '{1'b0, 1'b1, 1'b0};

  initial begin
    rstn = 1'b0;
    {i_arvalid, i_rready, d_arvalid, d_rready} = '0;
    {i_araddr, i_arlen, i_arsize} = '0;
    {d_araddr, d_arlen, d_arsize} = '0;
    {d_awvalid, d_awaddr, d_awlen, d_awsize} = '0;
    {d_wvalid, d_wdata, d_wstrb, d_wlast, d_bready} = '0;
    {arready, rvalid, rdata, rlast, rid} = '0;
    {awready, wready, bvalid, bresp} = '0;
    tick;
    tick;
    chk_reset;
    rstn = 1'b1;
    tick;

    // Round-robin: reset last_rd = 1, so icache wins first.
    i_arvalid = 1'b1;
    i_araddr  = 32'h0000_0100;
    d_arvalid = 1'b1;
    d_araddr  = 32'h0000_0200;
    for (int r = 0; r < 3; r++) begin
      settle;
      chk("rr_i_arready", {63'd0, i_arready}, {63'd0, !exp_dc[r]});
      chk("rr_d_arready", {63'd0, d_arready}, {63'd0, exp_dc[r]});
      tick;
      if (r == 2) begin
        i_arvalid = 1'b0;
        d_arvalid = 1'b0;
      end
      do_ar(exp_dc[r] ? 32'h200 : 32'h100, exp_dc[r] ? 4'd1 : 4'd0);
      do_r(exp_dc[r], 1);
    end

    // Icache-only 4-beat refill.
    i_arvalid = 1'b1;
    i_araddr  = 32'h1c00_0000;
    i_arlen   = 8'd3;
    i_arsize  = 3'd2;
    settle;
    chk("ic_arready", {63'd0, i_arready}, 64'd1);
    chk("ic_arvalid_n", {63'd0, arvalid}, 64'd0);
    tick;
    i_arvalid = 1'b0;
    chk("ic_arlen", {56'd0, arlen}, 64'd3);
    do_ar(32'h1c00_0000, 4'd0);
    do_r(1'b0, 4);
    i_arvalid = 1'b1;
    settle;
    chk("ic_idle_again", {63'd0, i_arready}, 64'd1);
    i_arvalid = 1'b0;
    tick;

    // Uncached dcache store.
    d_awvalid = 1'b1;
    d_awaddr  = 32'h1fd0_0004;
    d_awlen   = 8'd0;
    d_awsize  = 3'd2;
    settle;
    chk("st_awready", {63'd0, d_awready}, 64'd1);
    chk("st_awvalid0", {63'd0, awvalid}, 64'd0);
    tick;
    d_awvalid = 1'b0;
    settle;
    chk("st_awvalid1", {63'd0, awvalid}, 64'd1);
    chk("st_awaddr", {32'd0, awaddr}, 64'h1fd0_0004);
    chk("st_awid", {60'd0, awid}, 64'd1);
    awready = 1'b1;
    tick;
    awready  = 1'b0;
    d_wvalid = 1'b1;
    d_wdata  = 32'hdead_beef;
    d_wstrb  = 4'b0100;
    d_wlast  = 1'b1;
    wready   = 1'b1;
    settle;
    chk("st_wvalid", {63'd0, wvalid}, 64'd1);
    chk("st_wstrb", {60'd0, wstrb}, 64'h4);
    chk("st_wlast", {63'd0, wlast}, 64'd1);
    chk("st_wdata", {32'd0, wdata}, 64'hdead_beef);
    chk("st_d_wready", {63'd0, d_wready}, 64'd1);
    tick;
    {d_wvalid, d_wlast, wready} = '0;
    settle;
    chk("st_wvalid_off", {63'd0, wvalid}, 64'd0);
    chk("st_bvalid0", {63'd0, d_bvalid}, 64'd0);
    bvalid   = 1'b1;
    d_bready = 1'b1;
    settle;
    chk("st_bvalid1", {63'd0, d_bvalid}, 64'd1);
    chk("st_bready", {63'd0, bready}, 64'd1);
    tick;
    bvalid   = 1'b0;
    d_bready = 1'b0;

    // Write-back of line 0x1230 blocks a dcache read of 0x1238.
    d_awvalid = 1'b1;
    d_awaddr  = 32'h0000_1230;
    d_awlen   = 8'd3;
    tick;
    d_awvalid = 1'b0;
    d_arvalid = 1'b1;
    d_araddr  = 32'h0000_1238;
    i_arvalid = 1'b1;
    i_araddr  = 32'h0000_2000;
    i_arlen   = 8'd0;
    settle;
    chk("hz_d_blocked", {63'd0, d_arready}, 64'd0);
    chk("hz_i_granted", {63'd0, i_arready}, 64'd1);
    tick;
    i_arvalid = 1'b0;
    awready   = 1'b1;
    do_ar(32'h0000_2000, 4'd0);
    awready = 1'b0;
    do_r(1'b0, 1);
    for (int k = 0; k < 4; k++) begin
      d_wvalid = 1'b1;
      d_wdata  = 32'(k);
      d_wlast  = (k == 3);
      wready   = 1'b1;
      settle;
      chk("hz_d_wait", {63'd0, d_arready}, 64'd0);
      chk("hz_wvalid", {63'd0, wvalid}, 64'd1);
      tick;
    end
    {d_wvalid, d_wlast, wready} = '0;
    settle;
    chk("hz_d_resp", {63'd0, d_arready}, 64'd0);
    bvalid   = 1'b1;
    d_bready = 1'b1;
    tick;
    bvalid   = 1'b0;
    d_bready = 1'b0;
    settle;
    chk("hz_release", {63'd0, d_arready}, 64'd1);
    tick;
    d_arvalid = 1'b0;
    do_ar(32'h0000_1238, 4'd1);
    do_r(1'b1, 1);

    // arready withheld for 5 cycles.
    i_arvalid = 1'b1;
    i_araddr  = 32'h0000_3000;
    d_arvalid = 1'b1;
    d_araddr  = 32'h0000_4000;
    settle;
    chk("hold_grant", {63'd0, i_arready}, 64'd1);
    tick;
    i_arvalid = 1'b0;
    for (int k = 0; k < 5; k++) begin
      settle;
      chk("hold_arvalid", {63'd0, arvalid}, 64'd1);
      chk("hold_araddr", {32'd0, araddr}, 64'h3000);
      chk("hold_no_gnt", {63'd0, d_arready}, 64'd0);
      tick;
    end
    d_arvalid = 1'b0;
    do_ar(32'h0000_3000, 4'd0);
    do_r(1'b0, 2);

    // Reset in the middle of a burst and a write.
    d_awvalid = 1'b1;
    d_awaddr  = 32'h0000_6000;
    d_awlen   = 8'd0;
    i_arvalid = 1'b1;
    i_araddr  = 32'h0000_5000;
    i_arlen   = 8'd3;
    tick;
    d_awvalid = 1'b0;
    i_arvalid = 1'b0;
    settle;
    chk("mid_awvalid", {63'd0, awvalid}, 64'd1);
    do_ar(32'h0000_5000, 4'd0);
    rvalid   = 1'b1;
    i_rready = 1'b1;
    rdata    = 32'h1111_2222;
    tick;
    settle;
    chk("mid_rvalid", {63'd0, i_rvalid}, 64'd1);
    rstn = 1'b0;
    settle;
    chk_reset;
    {rvalid, i_rready, rdata} = '0;
    tick;
    rstn = 1'b1;
    tick;
    i_arvalid = 1'b1;
    i_araddr  = 32'h0000_7000;
    settle;
    chk("post_rst_gnt", {63'd0, i_arready}, 64'd1);
    tick;
    i_arvalid = 1'b0;
    do_ar(32'h0000_7000, 4'd0);
    do_r(1'b0, 4);

    $display("Simulation finished: %0d checks, %0d errors",
             n_chk, n_err);
    $finish;
  end

endmodule
